// File: rtl/wb_master_engine_pkg.sv
// Shared types and constants for the Wishbone classic master engine.
//   state_e      : engine FSM states
//   ST_*         : response status encodings
//   tmo_cnt_w()  : width of the bus-timeout counter for a given TIMEOUT
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUSERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // Counter must hold 0..TIMEOUT (it increments once more on the terminating edge).
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_master_engine_if.sv
// Wishbone B4 classic bus bundle between an initiator and a target.
//   cyc, stb, we, sel, adr, dat_w : initiator -> target
//   dat_r, ack, err               : target -> initiator
interface wb_master_engine_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  import wb_master_pkg::*;

  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_master_engine.sv
// Wishbone classic initiator: turns one command from a valid/ready channel
// into a single non-pipelined Wishbone read/write cycle and returns the read
// data plus a completion status (OK / bus error / timeout) on a valid/ready
// response channel.
//   wb_clk_i, wb_rst_ni          : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o      : command handshake
//   cmd_we_i/adr_i/dat_i/sel_i   : command payload
//   rsp_valid_o/rsp_ready_i      : response handshake
//   rsp_dat_o, rsp_status_o      : read data (0 for writes/failures), status
//   busy_o                       : engine not idle
//   wbm                          : Wishbone master port
module wb_master_engine
  import wb_master_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW-1:0]     cmd_dat_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic [1:0]        rsp_status_o,
  output logic              busy_o,
  wb_master_engine_if.master wbm
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = tmo_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            term_c;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cmd_ready_d  = cmd_ready_q;
    busy_d       = busy_q;
    term_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          cyc_d       = 1'b1;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = BUS;
        end
      end

      BUS: begin
        cnt_d = cnt_q + CW'(1);
        // err beats ack; either beats a timeout landing in the same cycle
        if (wbm.err) begin
          term_c       = 1'b1;
          rsp_status_d = ST_BUSERR;
          rsp_dat_d    = '0;
        end else if (wbm.ack) begin
          term_c       = 1'b1;
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? '0 : wbm.dat_r;
        end else if (cnt_q == CNT_LAST) begin
          term_c       = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_dat_d    = '0;
        end
        if (term_c) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        // Back to IDLE only; the next command is taken on a later edge.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  // cyc and stb are identical in classic single-transfer cycles.
  assign wbm.cyc      = cyc_q;
  assign wbm.stb      = cyc_q;
  assign wbm.we       = we_q;
  assign wbm.adr      = adr_q;
  assign wbm.dat_w    = dat_q;
  assign wbm.sel      = sel_q;
  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_wb_master_engine.sv
// Self-checking bench for wb_master_engine (TIMEOUT=15): table of single
// transfers with a scripted slave, plus backpressure and async-reset sequences.
module tb_wb_master_engine;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TMO = 15;

  typedef enum int unsigned { K_ACK, K_ERR, K_BOTH, K_NONE } kind_e;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int unsigned wait_n;
    kind_e       kind;
    logic [31:0] rdata;
    logic [1:0]  exp_status;
    logic [31:0] exp_dat;
    int unsigned exp_stb;
  } vec_t;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        vecs [8];

  wb_master_engine_if #(.AW(AW), .DW(DW)) wbm ();

  wb_master_engine #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_adr_i    (cmd_adr),
    .cmd_dat_i    (cmd_dat),
    .cmd_sel_i    (cmd_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_status_o (rsp_status),
    .busy_o       (busy),
    .wbm          (wbm.master)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Offer one command; the engine is idle so it is taken at the next edge.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Scripted slave: counts stb cycles, checks held fields, replies after wait_n cycles.
  task automatic run_bus(input int unsigned wait_n, input kind_e kind, input logic [31:0] rdata,
                         input logic [68:0] exp_fields, output int unsigned stb_cnt,
                         output int unsigned bad);
    stb_cnt = 0;
    bad     = 0;
    for (int n = 0; n < 40; n++) begin
      if (!wbm.stb) break;
      if (!wbm.cyc || ({wbm.we, wbm.adr, wbm.sel, wbm.dat_w} !== exp_fields)) bad++;
      stb_cnt++;
      if (kind != K_NONE && n == int'(wait_n)) begin
        wbm.ack   = (kind == K_ACK) || (kind == K_BOTH);
        wbm.err   = (kind == K_ERR) || (kind == K_BOTH);
        wbm.dat_r = rdata;
      end
      @(posedge wb_clk_i);
      #1;
      wbm.ack   = 1'b0;
      wbm.err   = 1'b0;
      wbm.dat_r = 32'hA5A5_A5A5;
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    int unsigned bad;
    logic [31:0] held_dat;

    //              we    adr           dat           sel   wait kind    rdata         st     exp_dat       stb
    vecs[0] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 0,  K_ACK,  32'hFFFF_FFFF, 2'b00, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 3,  K_ACK,  32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 4};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 0,  K_NONE, 32'h0,         2'b10, 32'h0,         15};
    vecs[3] = '{1'b0, 32'h3000_0030, 32'h0,         4'hF, 1,  K_BOTH, 32'h5555_AAAA, 2'b01, 32'h0,         2};
    vecs[4] = '{1'b0, 32'h3000_0040, 32'h0,         4'hF, 14, K_ACK,  32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 15};
    vecs[5] = '{1'b1, 32'h3000_0044, 32'h8765_4321, 4'h3, 2,  K_ERR,  32'h1111_1111, 2'b01, 32'h0,         3};
    vecs[6] = '{1'b0, 32'h3000_0048, 32'h0,         4'hC, 14, K_ERR,  32'h2222_2222, 2'b01, 32'h0,         15};
    vecs[7] = '{1'b1, 32'h3000_004C, 32'hAAAA_5555, 4'h1, 0,  K_NONE, 32'h0,         2'b10, 32'h0,         15};

    wb_rst_ni = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wbm.ack   = 1'b0;
    wbm.err   = 1'b0;
    wbm.dat_r = 32'hA5A5_A5A5;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i);
    #1;

    // Reset state
    chk("rst_cyc_stb_we", 64'({wbm.cyc, wbm.stb, wbm.we}), 64'(0));
    chk("rst_adr", 64'(wbm.adr), 64'(0));
    chk("rst_dat_sel", 64'({wbm.dat_w, wbm.sel}), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_dat, rsp_status}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Table-driven single transfers
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      run_bus(vecs[i].wait_n, vecs[i].kind, vecs[i].rdata,
              {vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat}, cnt, bad);
      chk($sformatf("v%0d_stb_cycles", i), 64'(cnt), 64'(vecs[i].exp_stb));
      chk($sformatf("v%0d_bus_fields", i), 64'(bad), 64'(0));
      chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(1));
      chk($sformatf("v%0d_status", i), 64'(rsp_status), 64'(vecs[i].exp_status));
      chk($sformatf("v%0d_rsp_dat", i), 64'(rsp_dat), 64'(vecs[i].exp_dat));
      chk($sformatf("v%0d_busy_ready", i), 64'({busy, cmd_ready}), 64'(2'b10));
      drain();
      chk($sformatf("v%0d_idle", i), 64'({rsp_valid, busy, cmd_ready, wbm.cyc}), 64'(4'b0010));
    end

    // Backpressure: response held, stray ack/err ignored, pending command waits
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    run_bus(0, K_ACK, 32'h0BAD_F00D, {1'b0, 32'h3000_0050, 4'hF, 32'h0}, cnt, bad);
    chk("bp_stb_cycles", 64'(cnt), 64'(1));
    held_dat  = 32'h0BAD_F00D;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0060;
    cmd_dat   = 32'h1111_2222;
    cmd_sel   = 4'hF;
    cmd_valid = 1'b1;
    wbm.ack   = 1'b1;
    wbm.err   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge wb_clk_i);
      #1;
      chk($sformatf("bp_hold%0d", k), 64'({rsp_valid, rsp_status, rsp_dat}),
          64'({1'b1, 2'b00, held_dat}));
      chk($sformatf("bp_block%0d", k), 64'({cmd_ready, wbm.stb}), 64'(0));
    end
    wbm.ack   = 1'b0;
    wbm.err   = 1'b0;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    #1;
    rsp_ready = 1'b0;
    chk("bp_release", 64'({rsp_valid, wbm.stb, cmd_ready}), 64'(3'b001));
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b0;
    chk("bp_accept", 64'({wbm.stb, cmd_ready, busy}), 64'(3'b101));
    run_bus(0, K_ACK, 32'h7777_7777, {1'b1, 32'h3000_0060, 4'hF, 32'h1111_2222}, cnt, bad);
    chk("bp2_fields", 64'({cnt, bad}), 64'({32'd1, 32'd0}));
    chk("bp2_rsp", 64'({rsp_valid, rsp_status, rsp_dat}), 64'({1'b1, 2'b00, 32'h0}));
    drain();

    // Asynchronous reset while the bus cycle is in flight
    issue(1'b0, 32'h3000_0070, 32'h0, 4'hF);
    @(posedge wb_clk_i);
    #1;
    chk("mid_stb_high", 64'({wbm.cyc, wbm.stb, busy}), 64'(3'b111));
    #2;
    wb_rst_ni = 1'b0;
    #1;
    chk("async_rst_drop", 64'({wbm.cyc, wbm.stb, rsp_valid, busy}), 64'(0));
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i);
    #1;
    chk("post_rst_idle", 64'({cmd_ready, busy, wbm.stb, rsp_valid}), 64'(4'b1000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
